// File: rtl/booth_mult_pkg.sv
// Shared types and width helpers for the radix-4 Booth sequential multiplier.
package booth_mult_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   typedef enum logic [2:0] {D_ZERO, D_P1, D_P2, D_M1, D_M2} digit_t;

   // Operands are extended by two bits so unsigned values survive signed recoding.
   function automatic int ext_w(input int w);
      return w + 2;
   endfunction

   function automatic int acc_w(input int w);
      return 2 * w + 2;
   endfunction

   function automatic int ndig(input int w);
      return (w + 2) / 2;
   endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: 3-bit overlapping multiplier window to signed digit.
module booth_r4_recoder
   import booth_mult_pkg::*;
(
   input  logic [2:0] window,
   output digit_t     digit
);

   always_comb begin
      digit = D_ZERO;
      case (window)
         3'b001, 3'b010: digit = D_P1;
         3'b011:         digit = D_P2;
         3'b100:         digit = D_M2;
         3'b101, 3'b110: digit = D_M1;
         default:        digit = D_ZERO;
      endcase
   end

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Optional early termination when remaining digits are all zero: BOOTH_MULT_EARLY_TERM_EN.
module booth_r4_seq_multiplier
   import booth_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   localparam int NDIG = ndig(WIDTH);
   localparam int EW   = ext_w(WIDTH);
   localparam int AW   = acc_w(WIDTH);
   localparam int CW   = $clog2(NDIG);

   state_t          state, state_nxt;
   logic [AW-1:0]   acc, acc_nxt, mcand, addend;
   logic [EW:0]     mplier, mplier_nxt;
   logic [EW-1:0]   a_ext, b_ext;
   logic [CW-1:0]   cnt;
   logic            cin, last;
   digit_t          digit;

   assign a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
   assign b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

   booth_r4_recoder u_recoder (
      .window (mplier[2:0]),
      .digit  (digit)
   );

   // Negative digits use one's complement plus carry-in to avoid a subtractor.
   always_comb begin
      addend = '0;
      cin    = 1'b0;
      case (digit)
         D_P1: addend = mcand;
         D_P2: addend = mcand << 1;
         D_M1: begin addend = ~mcand;        cin = 1'b1; end
         D_M2: begin addend = ~(mcand << 1); cin = 1'b1; end
         default: addend = '0;
      endcase
   end

   assign acc_nxt    = acc + addend + AW'(cin);
   assign mplier_nxt = {{2{mplier[EW]}}, mplier[EW:2]};

`ifdef BOOTH_MULT_EARLY_TERM_EN
   assign last = (cnt == CW'(NDIG - 1)) || (&mplier_nxt) || (~|mplier_nxt);
`else
   assign last = (cnt == CW'(NDIG - 1));
`endif

   assign in_ready = (state == IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = CALC;
         CALC:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
         product   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               acc    <= '0;
               mcand  <= {{(AW-EW){a_ext[EW-1]}}, a_ext};
               mplier <= {b_ext, 1'b0};
               cnt    <= '0;
            end
            CALC: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 2;
               mplier <= mplier_nxt;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  product   <= acc_nxt[2*WIDTH-1:0];
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Self-checking bench: directed vector table and corner sequences at WIDTH=8, random ops at WIDTH=16.
module tb_booth_r4_seq_multiplier;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        iv8 = 0, ir8, sm8 = 0, ov8, or8 = 0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] p8;

   logic        iv16 = 0, ir16, sm16 = 0, ov16, or16 = 0;
   logic [15:0] a16 = '0, b16 = '0;
   logic [31:0] p16;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   booth_r4_seq_multiplier #(.WIDTH(8)) dut8 (
      .clock(clk), .reset(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8));

   booth_r4_seq_multiplier #(.WIDTH(16)) dut16 (
      .clock(clk), .reset(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .signed_mode(sm16), .out_valid(ov16), .out_ready(or16), .product(p16));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Expected edges from accept to out_valid; with early termination the op ends once
   // the unconsumed part of the (value-extended) multiplier is 0 or -1.
   function automatic int exp_lat(input longint bv, input int nd);
`ifdef BOOTH_MULT_EARLY_TERM_EN
      for (int k = 1; k < nd; k++)
         if ((bv >>> (2*k-1)) == 0 || (bv >>> (2*k-1)) == -1) return k;
`endif
      return nd + int'(bv & 0);
   endfunction

   function automatic logic [63:0] ref_mul(input longint x, input longint y);
      return 64'(x * y);
   endfunction

   task automatic run8(input logic [7:0] ta, input logic [7:0] tb_b, input logic sm,
                       input logic [15:0] exp_p, input string nm);
      int lat;
      longint bv;
      bv = sm ? longint'($signed(tb_b)) : longint'(tb_b);
      @(negedge clk);
      chk({nm, " in_ready"}, 64'(ir8), 64'd1);
      a8 = ta; b8 = tb_b; sm8 = sm; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0; sm8 = ~sm;   // later mode changes must not affect the op
      lat = 0;
      while (!ov8 && lat < 40) begin @(posedge clk); #1; lat++; end
      chk({nm, " out_valid"}, 64'(ov8), 64'd1);
      chk({nm, " latency"}, 64'(lat), 64'(exp_lat(bv, 5)));
      chk({nm, " product"}, 64'(p8), 64'(exp_p));
      @(negedge clk); or8 = 1'b1;
      @(posedge clk); #1; or8 = 1'b0;
      chk({nm, " out_valid drop"}, 64'(ov8), 64'd0);
   endtask

   task automatic run16(input logic [15:0] ta, input logic [15:0] tb_b, input logic sm);
      int lat;
      longint av, bv;
      av = sm ? longint'($signed(ta))   : longint'(ta);
      bv = sm ? longint'($signed(tb_b)) : longint'(tb_b);
      @(negedge clk);
      a16 = ta; b16 = tb_b; sm16 = sm; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0; sm16 = ~sm;
      lat = 0;
      while (!ov16 && lat < 60) begin @(posedge clk); #1; lat++; end
      chk("w16 latency", 64'(lat), 64'(exp_lat(bv, 9)));
      chk("w16 product", 64'(p16), {32'd0, ref_mul(av, bv)[31:0]});
      @(negedge clk); or16 = 1'b1;
      @(posedge clk); #1; or16 = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sm;
      logic [15:0] p;
   } vec_t;

   initial begin
      vec_t vt[10];
      logic [15:0] held;
      int lat;
      vt[0] = '{8'hFD, 8'h07, 1'b1, 16'hFFEB};
      vt[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vt[2] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
      vt[3] = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vt[4] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
      vt[5] = '{8'd100, 8'd1, 1'b1, 16'h0064};
      vt[6] = '{8'd5,  8'd6,  1'b0, 16'h001E};
      vt[7] = '{8'h80, 8'h80, 1'b0, 16'h4000};
      vt[8] = '{8'h7F, 8'h80, 1'b0, 16'h3F80};
      vt[9] = '{8'h00, 8'hFF, 1'b1, 16'h0000};

      // Reset state
      #12;
      chk("reset in_ready", 64'(ir8), 64'd1);
      chk("reset out_valid", 64'(ov8), 64'd0);
      chk("reset product", 64'(p8), 64'd0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 10; i++) run8(vt[i].a, vt[i].b, vt[i].sm, vt[i].p, $sformatf("vec%0d", i));

      // Backpressure: result held, further requests ignored while busy
      @(negedge clk);
      a8 = 8'hFD; b8 = 8'h07; sm8 = 1'b1; iv8 = 1'b1;
      @(posedge clk); #1;
      a8 = 8'd5; b8 = 8'd6; sm8 = 1'b0;
      lat = 0;
      while (!ov8 && lat < 40) begin @(posedge clk); #1; lat++; end
      chk("bp first product", 64'(p8), 64'hFFEB);
      held = p8;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("bp out_valid held", 64'(ov8), 64'd1);
         chk("bp product held", 64'(p8), 64'(held));
         chk("bp in_ready low", 64'(ir8), 64'd0);
      end
      @(negedge clk); or8 = 1'b1;
      @(posedge clk); #1; or8 = 1'b0;
      chk("bp after hs in_ready", 64'(ir8), 64'd1);
      chk("bp after hs out_valid", 64'(ov8), 64'd0);
      @(posedge clk); #1; iv8 = 1'b0;
      chk("bp second accepted", 64'(ir8), 64'd0);
      lat = 0;
      while (!ov8 && lat < 40) begin @(posedge clk); #1; lat++; end
      chk("bp second latency", 64'(lat), 64'(exp_lat(64'sd6, 5)));
      chk("bp second product", 64'(p8), 64'h001E);
      @(negedge clk); or8 = 1'b1;
      @(posedge clk); #1; or8 = 1'b0;

      // Reset in the middle of the calculation aborts the op
      @(negedge clk);
      a8 = 8'h7F; b8 = 8'h6B; sm8 = 1'b1; iv8 = 1'b1;
      @(posedge clk); #1; iv8 = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b1; #1;
      chk("abort out_valid", 64'(ov8), 64'd0);
      chk("abort in_ready", 64'(ir8), 64'd1);
      chk("abort product", 64'(p8), 64'd0);
      @(negedge clk); rst = 1'b0;
      run8(8'd5, 8'd6, 1'b0, 16'h001E, "post-abort");

      // Random operands at WIDTH=16 against arithmetic reference
      run16(16'h8000, 16'h8000, 1'b1);
      run16(16'hFFFF, 16'hFFFF, 1'b0);
      for (int i = 0; i < 40; i++) run16(16'($urandom), 16'($urandom), 1'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
